// File: rtl/tap_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tap_rx_pkg
//  Description : Shared definitions for the tap_rx tape loader: nominal
//                ROM-loader pulse timings, decode threshold defaults, FSM
//                state encoding and a range-check helper.
//  Revision    : 1.0  initial release
// ============================================================================
package tap_rx_pkg;

    // Nominal half-period timings in 3.5 MHz clocks
    localparam int C_PILOT_HALF = 2168;
    localparam int C_SYNC1      = 667;
    localparam int C_SYNC2      = 735;
    localparam int C_ZERO       = 855;
    localparam int C_ONE        = 1710;

    // Acceptance windows and decode threshold defaults
    localparam int C_MIN_PILOT  = 256;
    localparam int C_PILOT_MIN  = 1800;
    localparam int C_PILOT_MAX  = 2600;
    localparam int C_SYNC_MIN   = 450;
    localparam int C_SYNC_MAX   = 1000;
    localparam int C_HALF_MIN   = 450;
    localparam int C_HALF_MAX   = 2000;
    localparam int C_BIT_THRESH = 2565;
    localparam int C_TIMEOUT    = 35000;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PILOT    = 3'd1,
        SYNC2    = 3'd2,
        DATA     = 3'd3,
        FLUSH_LO = 3'd4,
        FLUSH_HI = 3'd5
    } tap_state_t;

    function automatic logic in_range(input logic [15:0] w,
                                      input logic [15:0] lo,
                                      input logic [15:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tap_rx_pulse_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tap_rx_pulse_meter
//  Description : EAR synchroniser and edge detector. Measures the number of
//                clocks between successive edges (saturating at 0xFFFF) and
//                flags a timeout when no edge arrives for TIMEOUT clocks.
//                The edge strobe appears 3 clocks after ear moves.
//  Revision    : 1.0  initial release
// ============================================================================
module tap_rx_pulse_meter
    import tap_rx_pkg::*;
#(
    parameter int TIMEOUT = C_TIMEOUT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_ear,
    output logic        o_edge,
    output logic [15:0] o_width,
    output logic        o_timeout
);

    localparam logic [15:0] C_TMO_M1 = 16'(TIMEOUT - 1);

    logic        r_ear_s1;
    logic        r_ear_s2;
    logic        r_ear_d;
    logic [15:0] r_count;
    logic        r_edge;
    logic [15:0] r_width;
    logic        r_timeout;
    logic        w_edge;

    assign w_edge = r_ear_s2 ^ r_ear_d;

    // Synchronise ear, capture the half-period on each edge, count silence
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ear_s1  <= 1'b0;
            r_ear_s2  <= 1'b0;
            r_ear_d   <= 1'b0;
            r_count   <= 16'd0;
            r_edge    <= 1'b0;
            r_width   <= 16'd0;
            r_timeout <= 1'b0;
        end else begin
            r_ear_s1  <= i_ear;
            r_ear_s2  <= r_ear_s1;
            r_ear_d   <= r_ear_s2;
            r_edge    <= w_edge;
            r_timeout <= 1'b0;
            if (w_edge) begin
                r_width <= r_count;
                r_count <= 16'd1;
            end else begin
                if (r_count != 16'hFFFF)
                    r_count <= r_count + 16'd1;
                if (r_count == C_TMO_M1)
                    r_timeout <= 1'b1;
            end
        end
    end

    assign o_edge    = r_edge;
    assign o_width   = r_width;
    assign o_timeout = r_timeout;

endmodule
`default_nettype wire

// File: rtl/tap_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tap_rx
//  Description : Tape loader. Decodes the EAR pulse stream (pilot, sync,
//                data bit pairs) into TAP blocks in tape RAM: a 2-byte
//                little-endian length followed by the data, blocks packed
//                back to back from address 0.
//                Optional: TAP_RX_CHECKSUM_EN adds xor_ok, the result of a
//                running XOR over every byte of the last block.
//  Revision    : 1.0  initial release
// ============================================================================
module tap_rx
    import tap_rx_pkg::*;
#(
    parameter int MIN_PILOT  = C_MIN_PILOT,
    parameter int PILOT_MIN  = C_PILOT_MIN,
    parameter int PILOT_MAX  = C_PILOT_MAX,
    parameter int SYNC_MIN   = C_SYNC_MIN,
    parameter int SYNC_MAX   = C_SYNC_MAX,
    parameter int HALF_MIN   = C_HALF_MIN,
    parameter int HALF_MAX   = C_HALF_MAX,
    parameter int BIT_THRESH = C_BIT_THRESH,
    parameter int TIMEOUT    = C_TIMEOUT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ear,
    output logic [14:0] tap_address,
    output logic [7:0]  tap_wdata,
    output logic        tap_we,
    output logic        busy,
    output logic        block_done,
`ifdef TAP_RX_CHECKSUM_EN
    output logic        xor_ok,
`endif
    output logic        overflow
);

    tap_state_t  r_state;
    tap_state_t  w_state_nxt;
    logic [15:0] r_pcount;
    logic [15:0] r_half1;
    logic        r_have_half;
    logic [7:0]  r_shift;
    logic [2:0]  r_bitn;
    logic [15:0] r_len;
    logic [14:0] r_wr_ptr;
    logic [14:0] r_hdr_ptr;
    logic        r_overflow;
    logic        r_block_done;

    logic        w_edge;
    logic [15:0] w_width;
    logic        w_timeout;
    logic        w_is_pilot;
    logic        w_is_sync;
    logic        w_is_data;
    logic [16:0] w_sum;
    logic        w_bit;
    logic [7:0]  w_byte;
    logic        w_commit;
    logic        w_we;
    logic [14:0] w_addr;
    logic [7:0]  w_wdata;

    tap_rx_pulse_meter #(
        .TIMEOUT (TIMEOUT)
    ) u_meter (
        .clock     (clock),
        .reset     (reset),
        .i_ear     (ear),
        .o_edge    (w_edge),
        .o_width   (w_width),
        .o_timeout (w_timeout)
    );

    assign w_is_pilot = in_range(w_width, 16'(PILOT_MIN), 16'(PILOT_MAX));
    assign w_is_sync  = in_range(w_width, 16'(SYNC_MIN),  16'(SYNC_MAX));
    assign w_is_data  = in_range(w_width, 16'(HALF_MIN),  16'(HALF_MAX));
    assign w_sum      = {1'b0, r_half1} + {1'b0, w_width};
    assign w_bit      = (w_sum >= 17'(BIT_THRESH));
    assign w_byte     = {r_shift[6:0], w_bit};

    // State register
    always_ff @(posedge clock) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next state and RAM write port; the write cycle is the decode cycle
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_we        = 1'b0;
        w_addr      = 15'd0;
        w_wdata     = 8'd0;
        case (r_state)
            IDLE: begin
                if (w_edge && w_is_pilot)
                    w_state_nxt = PILOT;
            end
            PILOT: begin
                if (w_edge) begin
                    if (w_is_sync && (r_pcount >= 16'(MIN_PILOT)))
                        w_state_nxt = SYNC2;
                    else if (!w_is_pilot)
                        w_state_nxt = IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = IDLE;
                end
            end
            SYNC2: begin
                if (w_edge)
                    w_state_nxt = w_is_sync ? DATA : IDLE;
                else if (w_timeout)
                    w_state_nxt = IDLE;
            end
            DATA: begin
                if ((w_edge && !w_is_data) || (!w_edge && w_timeout)) begin
                    w_state_nxt = (r_len == 16'd0) ? IDLE : FLUSH_LO;
                end else if (w_edge && r_have_half && (r_bitn == 3'd0)) begin
                    w_commit = 1'b1;
                    if (!r_overflow) begin
                        w_we    = 1'b1;
                        w_addr  = r_wr_ptr;
                        w_wdata = w_byte;
                    end
                end
            end
            FLUSH_LO: begin
                w_we        = 1'b1;
                w_addr      = r_hdr_ptr;
                w_wdata     = r_len[7:0];
                w_state_nxt = FLUSH_HI;
            end
            FLUSH_HI: begin
                w_we        = 1'b1;
                w_addr      = r_hdr_ptr + 15'd1;
                w_wdata     = r_len[15:8];
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Pilot counting, bit assembly, pointers and completion pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pcount     <= 16'd0;
            r_half1      <= 16'd0;
            r_have_half  <= 1'b0;
            r_shift      <= 8'd0;
            r_bitn       <= 3'd0;
            r_len        <= 16'd0;
            r_wr_ptr     <= 15'd0;
            r_hdr_ptr    <= 15'd0;
            r_overflow   <= 1'b0;
            r_block_done <= 1'b0;
        end else begin
            r_block_done <= 1'b0;
            case (r_state)
                IDLE: r_pcount <= 16'd1;
                PILOT: begin
                    if (w_edge && w_is_pilot && (r_pcount != 16'hFFFF))
                        r_pcount <= r_pcount + 16'd1;
                end
                SYNC2: begin
                    if (w_edge && w_is_sync) begin
                        r_bitn      <= 3'd7;
                        r_len       <= 16'd0;
                        r_wr_ptr    <= r_hdr_ptr + 15'd2;
                        r_have_half <= 1'b0;
                        r_shift     <= 8'd0;
                    end
                end
                DATA: begin
                    if (w_edge && w_is_data) begin
                        if (!r_have_half) begin
                            r_half1     <= w_width;
                            r_have_half <= 1'b1;
                        end else begin
                            r_have_half <= 1'b0;
                            r_shift     <= w_byte;
                            r_bitn      <= r_bitn - 3'd1;
                        end
                    end
                    if (w_commit) begin
                        r_len <= r_len + 16'd1;
                        // The last RAM location is written once; the pointer
                        // never wraps back over the start of the tape.
                        if (!r_overflow) begin
                            if (r_wr_ptr == 15'h7FFF)
                                r_overflow <= 1'b1;
                            else
                                r_wr_ptr <= r_wr_ptr + 15'd1;
                        end
                    end
                end
                FLUSH_HI: begin
                    r_block_done <= 1'b1;
                    r_hdr_ptr    <= r_wr_ptr;
                end
                default: ;
            endcase
        end
    end

`ifdef TAP_RX_CHECKSUM_EN
    logic [7:0] r_xor;
    logic       r_xor_ok;

    // Running XOR over committed bytes, result latched with block_done
    always_ff @(posedge clock) begin
        if (reset) begin
            r_xor    <= 8'd0;
            r_xor_ok <= 1'b0;
        end else begin
            if ((r_state == SYNC2) && w_edge && w_is_sync)
                r_xor <= 8'd0;
            else if (w_commit)
                r_xor <= r_xor ^ w_byte;
            if (r_state == FLUSH_HI)
                r_xor_ok <= (r_xor == 8'd0);
        end
    end

    assign xor_ok = r_xor_ok;
`endif

    assign tap_we      = w_we;
    assign tap_address = w_addr;
    assign tap_wdata   = w_wdata;
    assign busy        = (r_state != IDLE);
    assign block_done  = r_block_done;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire
